// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: double-buffered stereo sample pair serialized MSB-first
// onto dacdat, framed by the codec's bclk/daclrc clocks sampled on mclk.
module i2s_dac_tx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  bclk,
  input  logic                  daclrc,
  input  logic [DATA_WIDTH-1:0] sample_l,
  input  logic [DATA_WIDTH-1:0] sample_r,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  dacdat,
  output logic                  underrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                  bclk_d;
  logic                  lrc_d;
  logic                  bclk_fall;
  logic                  lrc_fall;
  logic                  lrc_rise;
  logic                  lrc_edge;
  logic                  accept;
  logic [DATA_WIDTH-1:0] hold_l;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] act_l;
  logic [DATA_WIDTH-1:0] act_r;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         bit_cnt;
  logic                  load_pend;
  logic                  load_left;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      bclk_d <= 1'b0;
      lrc_d  <= 1'b0;
    end else begin
      bclk_d <= bclk;
      lrc_d  <= daclrc;
    end
  end

  assign bclk_fall    = bclk_d & ~bclk;
  assign lrc_fall     = lrc_d & ~daclrc;
  assign lrc_rise     = ~lrc_d & daclrc;
  assign lrc_edge     = lrc_fall | lrc_rise;
  assign sample_ready = ~hold_full;
  // a pair offered on the frame-start cycle bypasses the holding buffer
  assign accept       = sample_valid & ~hold_full & ~lrc_fall;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      act_l     <= '0;
      act_r     <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (lrc_fall) begin
        if (hold_full) begin
          act_l     <= hold_l;
          act_r     <= hold_r;
          hold_full <= 1'b0;
        end else if (sample_valid) begin
          act_l <= sample_l;
          act_r <= sample_r;
        end else begin
          act_l    <= '0;
          act_r    <= '0;
          underrun <= 1'b1;
        end
      end else if (accept) begin
        hold_l    <= sample_l;
        hold_r    <= sample_r;
        hold_full <= 1'b1;
      end
    end
  end

  // The shift register loads one mclk after the lrc edge, once act_l/act_r
  // are settled; the next bclk fall is still several mclk away.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      load_pend <= 1'b0;
      load_left <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      dacdat    <= 1'b0;
    end else begin
      load_pend <= lrc_edge;
      if (lrc_edge) begin
        load_left <= lrc_fall;
      end
      if (load_pend) begin
        shift   <= load_left ? act_l : act_r;
        bit_cnt <= CW'(DATA_WIDTH);
      end else if (bclk_fall && !lrc_edge) begin
        if (bit_cnt != '0) begin
          dacdat  <= shift[DATA_WIDTH-1];
          shift   <= shift << 1;
          bit_cnt <= bit_cnt - CW'(1);
        end else begin
          dacdat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: directed sample pairs, expected half-frame words queued
// by the stimulus and checked by an I2S receiver capturing on bclk rising edges.
module tb_i2s_dac_tx;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic        bclk = 1'b0;
  logic        daclrc = 1'b0;
  logic [7:0]  div = 8'd0;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        dacdat;
  logic        underrun;

  int          total = 0;
  int          bad = 0;
  logic [16:0] exp_q[$];  // bit 16 set: slot not checked
  int          ur_pulses = 0;
  int          ur_maxw = 0;
  int          ur_w = 0;
  logic        mon_lrc = 1'b0;
  logic        started = 1'b0;
  int          k = 0;
  int          word_idx = 0;
  logic [31:0] cap = '0;

  i2s_dac_tx #(.DATA_WIDTH(16)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .bclk         (bclk),
    .daclrc       (daclrc),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dacdat       (dacdat),
    .underrun     (underrun)
  );

  initial forever #40 mclk = ~mclk;

  // bclk = mclk/4 and daclrc = mclk/256, both changing on mclk falling edges
  initial forever begin
    @(negedge mclk);
    div    = div + 8'd1;
    bclk   = div[1];
    daclrc = div[7];
  end

  always @(negedge mclk) begin
    if (underrun === 1'b1) ur_w++;
    else if (ur_w != 0) begin
      ur_pulses++;
      if (ur_w > ur_maxw) ur_maxw = ur_w;
      ur_w = 0;
    end
  end

  // receiver: 32 bclk rises per half frame; rise 1 is the I2S delay slot
  always @(posedge bclk) begin
    logic [16:0] e;
    logic [31:0] want;
    if (daclrc !== mon_lrc) begin
      mon_lrc = daclrc;
      started = 1'b1;
      k = 1;
      cap = {31'b0, dacdat};
    end else begin
      k++;
      cap = {cap[30:0], dacdat};
    end
    if (started && k == 32) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL word_extra idx=%0d got=%h required=none", word_idx, cap);
      end else begin
        e = exp_q.pop_front();
        if (!e[16]) begin
          want = {1'b0, e[15:0], 15'b0};
          total++;
          if (cap !== want) begin
            bad++;
            $display("FAIL word idx=%0d got=%h required=%h", word_idx, cap, want);
          end
        end
      end
      word_idx++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({1'b0, l});
    exp_q.push_back({1'b0, r});
  endtask

  // called just after a mclk falling edge
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && n < 1000) begin
      @(negedge mclk);
      n++;
    end
    check("handshake", {31'b0, sample_ready}, 32'd1);
    @(negedge mclk);
    sample_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic err;
    sample_valid = 1'b0;
    sample_l = '0;
    sample_r = '0;
    exp_q.push_back(17'h0);  // first half after reset is a right slot: act_r = 0

    repeat (3) @(negedge mclk);
    check("rst_dacdat", {31'b0, dacdat}, 32'd0);
    check("rst_underrun", {31'b0, underrun}, 32'd0);
    check("rst_ready", {31'b0, sample_ready}, 32'd1);
    rst = 1'b1;
    @(negedge mclk);

    push_pair(16'hA5C3, 16'h0F01);
    send_pair(16'hA5C3, 16'h0F01);
    check("ready_after_accept", {31'b0, sample_ready}, 32'd0);
    @(negedge daclrc);
    repeat (4) @(negedge mclk);
    check("ready_after_copy", {31'b0, sample_ready}, 32'd1);
    check("no_underrun_f1", ur_pulses, 32'd0);

    push_pair(16'h0000, 16'h0000);
    @(negedge daclrc);
    repeat (4) @(negedge mclk);
    check("underrun_count", ur_pulses, 32'd1);
    check("underrun_width", ur_maxw, 32'd1);

    push_pair(16'h1234, 16'hFEDC);
    @(negedge daclrc);
    sample_l = 16'h1234;
    sample_r = 16'hFEDC;
    sample_valid = 1'b1;
    @(negedge mclk);
    sample_valid = 1'b0;
    check("ready_direct", {31'b0, sample_ready}, 32'd1);
    repeat (3) @(negedge mclk);
    check("no_underrun_direct", ur_pulses, 32'd1);

    push_pair(16'h1111, 16'h2222);
    push_pair(16'h3333, 16'h4444);
    send_pair(16'h1111, 16'h2222);
    check("ready_drop_b2b", {31'b0, sample_ready}, 32'd0);
    send_pair(16'h3333, 16'h4444);
    check("second_held", {31'b0, sample_ready}, 32'd0);

    @(negedge daclrc);
    exp_q.push_back(17'h1_0000);  // left word cut by reset
    exp_q.push_back(17'h0);       // act_r cleared by reset
    send_pair(16'h5555, 16'hAAAA);
    @(negedge daclrc);
    send_pair(16'h6666, 16'h9999);  // pending pair lost to reset
    repeat (30) @(negedge mclk);
    rst = 1'b0;
    #50;
    check("midrst_dacdat", {31'b0, dacdat}, 32'd0);
    check("midrst_underrun", {31'b0, underrun}, 32'd0);
    check("midrst_ready", {31'b0, sample_ready}, 32'd1);
    #50;
    rst = 1'b1;
    err = 1'b0;
    n = 0;
    while (daclrc == 1'b0 && n < 400) begin
      @(negedge mclk);
      if (dacdat !== 1'b0) err = 1'b1;
      n++;
    end
    check("dacdat_zero_after_rst", {31'b0, err}, 32'd0);

    push_pair(16'h8000, 16'h7FFF);
    send_pair(16'h8000, 16'h7FFF);
    @(negedge daclrc);
    repeat (4) @(negedge mclk);
    check("underrun_final", ur_pulses, 32'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge mclk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
